// File: rtl/fp_seq_multiplier.sv
// rtl/fp_seq_multiplier.sv - multi-cycle IEEE-754 single-precision shift-add multiplier, RNE rounding
// Define FP_SEQ_MUL_DENORM_EN for gradual underflow; default build is DAZ/FTZ.
module fp_seq_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  flags
);
  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [23:0]       mcand_q, mcand_d, mplier_q, mplier_d;
  logic [47:0]       acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [23:0]       mant_q, mant_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;
  logic              spec_q, spec_d;
  logic [31:0]       out_q, out_d;
  logic [3:0]        flags_q, flags_d;

  logic [7:0]  ea, eb, ea_eff, eb_eff;
  logic [23:0] ma, mb;
  logic        sgn, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic [24:0] psum;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    sgn    = a_q[31] ^ b_q[31];
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_snan = a_nan && !a_q[22];
    b_snan = b_nan && !b_q[22];
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
`ifdef FP_SEQ_MUL_DENORM_EN
    a_zero = (a_q[30:0] == 31'd0);
    b_zero = (b_q[30:0] == 31'd0);
    ma     = {ea != 8'd0, a_q[22:0]};
    mb     = {eb != 8'd0, b_q[22:0]};
    ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    eb_eff = (eb == 8'd0) ? 8'd1 : eb;
`else
    // Subnormal operands count as zero, so the implicit bit is always 1 here.
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    ma     = {1'b1, a_q[22:0]};
    mb     = {1'b1, b_q[22:0]};
    ea_eff = ea;
    eb_eff = eb;
`endif
    psum = {1'b0, acc_q[47:24]} + {1'b0, (mplier_q[0] ? mcand_q : 24'd0)};
  end

`ifdef FP_SEQ_MUL_DENORM_EN
  logic [5:0]  lzc;
  logic [46:0] norm_sh;
  always_comb begin
    lzc = 6'd0;
    for (int i = 0; i < 47; i++) begin
      if (acc_q[i]) lzc = 6'(46 - i);
    end
    norm_sh = acc_q[46:0] << lzc;
  end
`endif

  logic [24:0]       rnd_sum;
  logic [22:0]       mant_r;
  logic signed [9:0] exp_r;
  logic              inexact;
  logic [31:0]       rnd_out;
  logic [3:0]        rnd_flags;
`ifdef FP_SEQ_MUL_DENORM_EN
  logic [4:0]  sh_amt;
  logic [49:0] sh_wide;
  logic [24:0] sub_v;
  logic        sub_st, sub_inx;
  logic [23:0] sub_r;
`endif

  always_comb begin
    rnd_sum = {1'b0, mant_q} + {24'd0, guard_q & (sticky_q | mant_q[0])};
    mant_r  = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
    exp_r   = rnd_sum[24] ? exp_q + 10'sd1 : exp_q;
    inexact = guard_q | sticky_q;
`ifdef FP_SEQ_MUL_DENORM_EN
    // Tiny results: denormalise to a fixed lsb weight of 2^-149 before rounding.
    sh_amt  = (exp_q <= -10'sd24) ? 5'd25 : 5'(10'sd1 - exp_q);
    sh_wide = {mant_q, guard_q, 25'd0} >> sh_amt;
    sub_v   = sh_wide[49:25];
    sub_st  = sticky_q | (|sh_wide[24:0]);
    sub_inx = sub_v[0] | sub_st;
    sub_r   = sub_v[24:1] + {23'd0, sub_v[0] & (sub_st | sub_v[1])};
    if (exp_q <= 10'sd0) begin
      rnd_out   = {sign_q, 7'd0, sub_r};
      rnd_flags = {2'b00, sub_inx, sub_inx};
    end else if (exp_r >= 10'sd255) begin
      rnd_out   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = 4'b0101;
    end else begin
      rnd_out   = {sign_q, exp_r[7:0], mant_r};
      rnd_flags = {3'b000, inexact};
    end
`else
    if (exp_r >= 10'sd255) begin
      rnd_out   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = 4'b0101;
    end else if (exp_r <= 10'sd0) begin
      rnd_out   = {sign_q, 31'd0};
      rnd_flags = 4'b0011;
    end else begin
      rnd_out   = {sign_q, exp_r[7:0], mant_r};
      rnd_flags = {3'b000, inexact};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    spec_d   = spec_q;
    out_d    = out_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d   = sgn;
        exp_d    = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - 10'sd127;
        mcand_d  = ma;
        mplier_d = mb;
        acc_d    = 48'd0;
        cnt_d    = 5'd0;
        spec_d   = 1'b1;
        state_d  = ROUND;
        // Special results bypass the datapath and are committed as-is in ROUND.
        if (a_nan || b_nan) begin
          out_d   = 32'h7FC00000;
          flags_d = {a_snan | b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
          out_d   = 32'h7FC00000;
          flags_d = 4'b1000;
        end else if (a_inf || b_inf) begin
          out_d   = {sgn, 8'hFF, 23'd0};
          flags_d = 4'b0000;
        end else if (a_zero || b_zero) begin
          out_d   = {sgn, 31'd0};
          flags_d = 4'b0000;
        end else begin
          spec_d  = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d    = {psum, acc_q[23:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = NORM;
      end
      NORM: begin
        state_d = ROUND;
        if (acc_q[47]) begin
          mant_d   = acc_q[47:24];
          guard_d  = acc_q[23];
          sticky_d = |acc_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
`ifdef FP_SEQ_MUL_DENORM_EN
          mant_d   = norm_sh[46:23];
          guard_d  = norm_sh[22];
          sticky_d = |norm_sh[21:0];
          exp_d    = exp_q - $signed({4'b0000, lzc});
`else
          mant_d   = acc_q[46:23];
          guard_d  = acc_q[22];
          sticky_d = |acc_q[21:0];
`endif
        end
      end
      ROUND: begin
        state_d = DONE;
        if (!spec_q) begin
          out_d   = rnd_out;
          flags_d = rnd_flags;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mcand_q  <= 24'd0;
      mplier_q <= 24'd0;
      acc_q    <= 48'd0;
      cnt_q    <= 5'd0;
      mant_q   <= 24'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      spec_q   <= 1'b0;
      out_q    <= 32'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      spec_q   <= spec_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_seq_multiplier.sv
// tb/tb_fp_seq_multiplier.sv - self-checking bench for fp_seq_multiplier (vector table plus random vs. exact-arithmetic model)
module tb_fp_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, res;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_seq_multiplier dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .out(res), .out_valid(out_valid), .out_ready(out_ready), .flags(flags)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Exact reference: integer significand product, then RNE to 24 bits with IEEE exponent range.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y, output bit sp);
    logic   s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, snan, inx, up, tiny;
    longint sx, sy, p, q, rem, half;
    int     ex, ey, e2, m, lsb, sh, bexp;
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
`ifdef FP_SEQ_MUL_DENORM_EN
    x_zero = (x[30:0] == 0);
    y_zero = (y[30:0] == 0);
`else
    x_zero = (x[30:23] == 0);
    y_zero = (y[30:23] == 0);
`endif
    snan = (x_nan && !x[22]) || (y_nan && !y[22]);
    sp   = 1'b1;
    if (x_nan || y_nan) return {snan, 3'b000, 32'h7FC00000};
    if ((x_inf && y_zero) || (x_zero && y_inf)) return {4'b1000, 32'h7FC00000};
    if (x_inf || y_inf) return {4'b0000, s, 31'h7F800000};
    if (x_zero || y_zero) return {4'b0000, s, 31'd0};
    sp = 1'b0;
    if (x[30:23] == 0) begin sx = longint'(x[22:0]); ex = -149; end
    else begin sx = longint'(x[22:0]) + (longint'(1) << 23); ex = int'(x[30:23]) - 150; end
    if (y[30:23] == 0) begin sy = longint'(y[22:0]); ey = -149; end
    else begin sy = longint'(y[22:0]) + (longint'(1) << 23); ey = int'(y[30:23]) - 150; end
    p  = sx * sy;
    e2 = ex + ey;
    m  = 0;
    for (int i = 0; i < 48; i++) if (p[i]) m = i;
    lsb  = m + e2 - 23;
    tiny = 1'b0;
`ifdef FP_SEQ_MUL_DENORM_EN
    tiny = (m + e2) < -126;
    if (lsb < -149) lsb = -149;
`endif
    sh = lsb - e2;
    if (sh <= 0) begin
      q = p << (-sh); inx = 1'b0; up = 1'b0;
    end else if (sh >= 60) begin
      q = 0; inx = (p != 0); up = 1'b0;
    end else begin
      q    = p >> sh;
      rem  = p & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      up   = (rem > half) || ((rem == half) && q[0]);
    end
    if (up) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = q >> 1; lsb = lsb + 1; end
    bexp = lsb + 150;
    if (q < (longint'(1) << 23)) return {2'b00, tiny && inx, inx, s, 8'd0, q[22:0]};
    if (bexp >= 255) return {4'b0101, s, 31'h7F800000};
    if (bexp <= 0) return {4'b0011, s, 31'd0};
    return {2'b00, tiny && inx, inx, s, 8'(bexp), q[22:0]};
  endfunction

  // One transaction; noise keeps in_valid high with junk operands while busy, hold delays out_ready.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit noise, input int hold,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL in_ready_timeout"); end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    if (noise) begin a = $urandom; b = $urandom; end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b0;
    if (!out_valid) begin checks++; errors++; $display("FAIL out_valid_timeout: got 0 expected 1"); end
    r = res; f = flags;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_out", res, r);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      1, 2: v[30:23] = 8'($urandom_range(100, 154));
      3: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(215, 254));
      4: v[30:23] = 8'd0;
      5: begin
        if ($urandom_range(0, 1) == 1) v[30:0] = 31'd0;
        else v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) v[22:0] = 23'd0;
      end
      default: ;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] r;
  logic [3:0]  f;
  logic [35:0] expv;
  logic [31:0] x, y;
  int          lat;
  bit          sp;

  initial begin
    vecs[0]  = '{32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 27};
    vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2};
    vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 27};
    vecs[3]  = '{32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101, 27};
    vecs[4]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27};
`ifdef FP_SEQ_MUL_DENORM_EN
    vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, 27};
`else
    vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 27};
`endif
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 2};
    vecs[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2};
    vecs[9]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 4'b0000, 2};
    vecs[10] = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 2};
    vecs[11] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 4'b0000, 27};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", res, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, 0, r, f, lat);
      chk($sformatf("vec%0d_out", i), r, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), {28'd0, f}, {28'd0, vecs[i].f});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held for 10 cycles with in_valid noise that must be ignored.
    run_op(32'h40400000, 32'h40200000, 1'b1, 10, r, f, lat);
    chk("bp_out", r, 32'h40F00000);
    chk("bp_flags", {28'd0, f}, 32'd0);

    // Reset in the middle of MUL aborts the operation immediately.
    a = 32'h40400000; b = 32'h40200000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out", res, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3F800001, 32'h3F800001, 1'b0, 0, r, f, lat);
    chk("postrst_out", r, 32'h3F800002);
    chk("postrst_flags", {28'd0, f}, 32'd1);
    chk("postrst_latency", 32'(lat), 32'd27);

    for (int i = 0; i < 300; i++) begin
      x = rand_op();
      y = rand_op();
      expv = ref_mul(x, y, sp);
      run_op(x, y, (i % 2) == 1, 0, r, f, lat);
      chk($sformatf("rand_out %h*%h", x, y), r, expv[31:0]);
      chk($sformatf("rand_flags %h*%h", x, y), {28'd0, f}, {28'd0, expv[35:32]});
      chk($sformatf("rand_latency %h*%h", x, y), 32'(lat), sp ? 32'd2 : 32'd27);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
